// File: rtl/fdd_pkg.sv
// Shared constants and state encoding for the floppy track buffer sequencer.
package fdd_pkg;
  localparam int SECTORS      = 13;
  localparam int SECTOR_BYTES = 512;
  localparam int TRACK_BYTES  = SECTORS * SECTOR_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH_REQ,
    FLUSH_WAIT,
    LOAD_REQ,
    LOAD_WAIT
  } fdd_state_t;
endpackage

// File: rtl/fdd_dirty_tracker.sv
// Per-sector dirty mask with set/clear/clear-all and a lowest-set-bit encoder.
// The encoder looks at the mask as it will be after this cycle's clears.
module fdd_dirty_tracker #(
  parameter int SECTORS = fdd_pkg::SECTORS,
  parameter int SEC_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [SEC_W-1:0]   set_idx,
  input  logic               clr_en,
  input  logic [SEC_W-1:0]   clr_idx,
  input  logic               clr_all,
  output logic [SECTORS-1:0] mask,
  output logic [SEC_W-1:0]   first_idx,
  output logic               any
);
  localparam logic [SECTORS-1:0] ONE = 1;

  logic [SECTORS-1:0] remain;
  logic [SECTORS-1:0] set_vec;

  // Out-of-range indices shift the single bit off the top and become no-ops.
  assign set_vec = set_en ? (ONE << set_idx) : '0;

  always_comb begin
    remain = mask;
    if (clr_en)  remain = remain & ~(ONE << clr_idx);
    if (clr_all) remain = '0;
  end

  always_comb begin
    first_idx = '0;
    for (int i = SECTORS - 1; i >= 0; i--) begin
      if (remain[i]) first_idx = SEC_W'(i);
    end
  end

  assign any = |remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mask <= '0;
    else if (clr_all) mask <= '0;
    else              mask <= remain | set_vec;
  end
endmodule

// File: rtl/fdd_track_sequencer.sv
// Loads a 13-sector track into the floppy buffer from SD and writes dirty sectors back
// before the buffer is reused; the CPU is held whenever an SD transfer is pending.
module fdd_track_sequencer #(
  parameter int SECTORS = fdd_pkg::SECTORS,
  parameter int TRACK_W = 6,
  parameter int SEC_W   = 4
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               img_readonly,
  input  logic               fd_write_disk,
  input  logic [13:0]        fd_track_addr,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  output logic [SEC_W-1:0]   buf_sec,
  output logic               cpu_wait,
  output logic               trk_valid,
  output logic [SECTORS-1:0] dirty
);
  import fdd_pkg::*;

  fdd_state_t         state, state_nxt;
  logic [TRACK_W-1:0] cur_track, cur_track_nxt;
  logic               mounted, readonly;
  logic               pend, pend_nxt;
  logic               trk_valid_nxt;
  logic [SEC_W-1:0]   buf_sec_nxt;
  logic               sd_rd_nxt, sd_wr_nxt;
  logic [31:0]        sd_lba_nxt;
  logic               ack_q, ack_rise, ack_fall;
  logic               set_en, clr_en, any_dirty;
  logic [SEC_W-1:0]   first_idx;
  logic [SEC_W-1:0]   wr_sec;
  logic [31:0]        lba_now;
  logic               unused_addr_bits;

  assign wr_sec           = fd_track_addr[9 +: SEC_W];
  assign unused_addr_bits = ^{fd_track_addr[13], fd_track_addr[8:0]};
  assign ack_rise         = sd_ack & ~ack_q;
  assign ack_fall         = ~sd_ack & ack_q;
  assign lba_now          = 32'(SECTORS) * 32'(cur_track) + 32'(buf_sec);

  fdd_dirty_tracker #(.SECTORS(SECTORS), .SEC_W(SEC_W)) u_dirty (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .set_en    (set_en),
    .set_idx   (wr_sec),
    .clr_en    (clr_en),
    .clr_idx   (buf_sec),
    .clr_all   (img_mounted),
    .mask      (dirty),
    .first_idx (first_idx),
    .any       (any_dirty)
  );

  always_comb begin
    state_nxt     = state;
    cur_track_nxt = cur_track;
    pend_nxt      = pend;
    trk_valid_nxt = trk_valid;
    buf_sec_nxt   = buf_sec;
    sd_rd_nxt     = sd_rd;
    sd_wr_nxt     = sd_wr;
    sd_lba_nxt    = sd_lba;
    set_en        = 1'b0;
    clr_en        = 1'b0;
    unique case (state)
      IDLE: begin
        // A mount pulse defers the decision one cycle so the new flags are in place.
        if (!img_mounted) begin
          if (!pend && (track != cur_track) && any_dirty) begin
            buf_sec_nxt = first_idx;
            state_nxt   = FLUSH_REQ;
          end else if (pend || (track != cur_track)) begin
            cur_track_nxt = track;
            pend_nxt      = 1'b0;
            trk_valid_nxt = 1'b0;
            if (mounted) begin
              buf_sec_nxt = '0;
              state_nxt   = LOAD_REQ;
            end
          end else if (fd_write_disk && trk_valid && !readonly && (32'(wr_sec) < 32'(SECTORS))) begin
            set_en = 1'b1;
          end
        end
      end
      FLUSH_REQ: begin
        sd_lba_nxt = lba_now;
        sd_wr_nxt  = 1'b1;
        state_nxt  = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (ack_rise) sd_wr_nxt = 1'b0;
        if (ack_fall) begin
          clr_en = 1'b1;
          if (any_dirty) begin
            buf_sec_nxt = first_idx;
            state_nxt   = FLUSH_REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      LOAD_REQ: begin
        sd_lba_nxt = lba_now;
        sd_rd_nxt  = 1'b1;
        state_nxt  = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (ack_rise) sd_rd_nxt = 1'b0;
        if (ack_fall) begin
          if (buf_sec == SEC_W'(SECTORS - 1)) begin
            trk_valid_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            buf_sec_nxt = buf_sec + SEC_W'(1);
            state_nxt   = LOAD_REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (img_mounted) begin
      pend_nxt      = 1'b1;
      trk_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_track <= '0;
      mounted   <= 1'b0;
      readonly  <= 1'b0;
      pend      <= 1'b0;
      trk_valid <= 1'b0;
      buf_sec   <= '0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      sd_lba    <= '0;
      cpu_wait  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_track <= cur_track_nxt;
      pend      <= pend_nxt;
      trk_valid <= trk_valid_nxt;
      buf_sec   <= buf_sec_nxt;
      sd_rd     <= sd_rd_nxt;
      sd_wr     <= sd_wr_nxt;
      sd_lba    <= sd_lba_nxt;
      cpu_wait  <= (state_nxt != IDLE);
      ack_q     <= sd_ack;
      if (img_mounted) begin
        mounted  <= img_present;
        readonly <= img_readonly;
      end
    end
  end
endmodule

// File: tb/tb_fdd_track_sequencer.sv
// Randomized bench for fdd_track_sequencer: a transaction-level model predicts the SD
// request stream, dirty mask and track-valid flag; an SD responder acks with random delays.
module tb_fdd_track_sequencer;
  localparam int SECTORS = 13;
  localparam int TRACK_W = 6;
  localparam int SEC_W   = 4;

  logic               clk_sys = 1'b0;
  logic               reset_n = 1'b1;
  logic [TRACK_W-1:0] track = '0;
  logic               img_mounted = 1'b0;
  logic               img_present = 1'b0;
  logic               img_readonly = 1'b0;
  logic               fd_write_disk = 1'b0;
  logic [13:0]        fd_track_addr = '0;
  logic [31:0]        sd_lba;
  logic               sd_rd, sd_wr;
  logic               sd_ack = 1'b0;
  logic [SEC_W-1:0]   buf_sec;
  logic               cpu_wait, trk_valid;
  logic [SECTORS-1:0] dirty;

  fdd_track_sequencer #(.SECTORS(SECTORS), .TRACK_W(TRACK_W), .SEC_W(SEC_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
    .img_mounted(img_mounted), .img_present(img_present), .img_readonly(img_readonly),
    .fd_write_disk(fd_write_disk), .fd_track_addr(fd_track_addr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .buf_sec(buf_sec), .cpu_wait(cpu_wait), .trk_valid(trk_valid), .dirty(dirty)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
    logic [3:0]  sec;
  } req_t;

  int   tests = 0;
  int   fails = 0;
  req_t exp_q[$];
  req_t log_q[$];

  int       m_cur = 0;
  bit       m_mounted = 0, m_ro = 0, m_valid = 0;
  bit [12:0] m_dirty = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endfunction

  function automatic void push_req(input bit wr, input int t, input int s);
    req_t r;
    r.wr  = wr;
    r.lba = 32'(SECTORS * t + s);
    r.sec = 4'(s);
    exp_q.push_back(r);
  endfunction

  // Negedge: observe requests against the model, then advance the SD responder.
  int rsp_phase = 0;
  int rsp_cnt   = 0;
  bit req_prev  = 0;
  always @(negedge clk_sys) begin
    logic req;
    req_t got, want;
    req = sd_rd | sd_wr;
    if (!reset_n) begin
      sd_ack    = 1'b0;
      rsp_phase = 0;
      req_prev  = 0;
    end else begin
      if (req) begin
        check("rd_wr_exclusive", {sd_rd, sd_wr}, (sd_rd ? 2'b10 : 2'b01));
        check("cpu_wait_during_req", cpu_wait, 1'b1);
      end
      if (req && !req_prev) begin
        got.wr  = sd_wr;
        got.lba = sd_lba;
        got.sec = buf_sec;
        log_q.push_back(got);
        check("req_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("req_wr_lba_sec", got, want);
        end
      end
      case (rsp_phase)
        0: if (req) begin rsp_cnt = $urandom_range(1, 10); rsp_phase = 1; end
        1: begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin sd_ack = 1'b1; rsp_phase = 2; end
        end
        2: if (!req) begin rsp_cnt = $urandom_range(1, 4); rsp_phase = 3; end
        default: begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin sd_ack = 1'b0; rsp_phase = 0; end
        end
      endcase
      req_prev = req;
    end
  end

  task automatic wait_quiet(input string name);
    int q = 0;
    int n = 0;
    while (q < 6 && n < 3000) begin
      @(negedge clk_sys);
      n++;
      if (exp_q.size() == 0 && !cpu_wait && !sd_rd && !sd_wr && !sd_ack) q++;
      else q = 0;
    end
    check({name, "_settle"}, n < 3000, 1'b1);
    check({name, "_dirty"}, dirty, m_dirty);
    check({name, "_trk_valid"}, trk_valid, m_valid);
  endtask

  task automatic set_track(input int t);
    @(negedge clk_sys);
    track = TRACK_W'(t);
    if (t != m_cur) begin
      for (int s = 0; s < SECTORS; s++)
        if (m_dirty[s]) push_req(1'b1, m_cur, s);
      m_dirty = '0;
      m_cur   = t;
      m_valid = m_mounted;
      if (m_mounted)
        for (int s = 0; s < SECTORS; s++) push_req(1'b0, t, s);
    end
  endtask

  task automatic mount(input bit present, input bit ro);
    @(negedge clk_sys);
    img_mounted  = 1'b1;
    img_present  = present;
    img_readonly = ro;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    m_dirty   = '0;
    m_mounted = present;
    m_ro      = ro;
    m_valid   = present;
    m_cur     = int'(track);
    if (present)
      for (int s = 0; s < SECTORS; s++) push_req(1'b0, m_cur, s);
  endtask

  task automatic write_byte(input logic [13:0] addr);
    int sec;
    @(negedge clk_sys);
    fd_write_disk = 1'b1;
    fd_track_addr = addr;
    @(negedge clk_sys);
    fd_write_disk = 1'b0;
    sec = int'(addr[12:9]);
    if (m_valid && !m_ro && sec < SECTORS) m_dirty[sec] = 1'b1;
  endtask

  function automatic int count_writes();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].wr) n++;
    return n;
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int n;
    #2 reset_n = 1'b0;
    #1;
    check("rst_outputs", {sd_lba, sd_rd, sd_wr, buf_sec, cpu_wait, trk_valid, dirty}, '0);
    repeat (3) @(negedge clk_sys);
    check("rst_outputs_held", {sd_lba, sd_rd, sd_wr, cpu_wait, trk_valid}, '0);
    reset_n = 1'b1;
    wait_quiet("idle_unmounted");

    // First mount loads track 0.
    log_q.delete();
    mount(1'b1, 1'b0);
    wait_quiet("load_t0");
    check("t0_count", log_q.size(), 13);
    if (log_q.size() == 13) begin
      check("t0_first", log_q[0], {1'b0, 32'd0, 4'd0});
      check("t0_last", log_q[12], {1'b0, 32'd12, 4'd12});
    end
    check("t0_valid_lit", {trk_valid, cpu_wait}, 2'b10);

    log_q.delete();
    set_track(5);
    wait_quiet("load_t5");
    if (log_q.size() == 13) begin
      check("t5_first", log_q[0], {1'b0, 32'd65, 4'd0});
      check("t5_last", log_q[12], {1'b0, 32'd77, 4'd12});
    end

    // Dirty sectors 2 and 12 are flushed before track 6 is loaded.
    write_byte(14'h0400);
    write_byte(14'h1800);
    check("dirty_2_12", dirty, 13'h1004);
    log_q.delete();
    set_track(6);
    wait_quiet("flush_t5_load_t6");
    check("t6_count", log_q.size(), 15);
    if (log_q.size() == 15) begin
      check("flush_a", log_q[0], {1'b1, 32'd67, 4'd2});
      check("flush_b", log_q[1], {1'b1, 32'd77, 4'd12});
      check("t6_first", log_q[2], {1'b0, 32'd78, 4'd0});
      check("t6_last", log_q[14], {1'b0, 32'd90, 4'd12});
    end

    // Read-only image: writes never mark sectors dirty.
    mount(1'b1, 1'b1);
    wait_quiet("ro_reload");
    write_byte(14'h0600);
    check("ro_dirty", dirty, 13'h0);
    log_q.delete();
    set_track(7);
    wait_quiet("ro_track7");
    check("ro_no_writes", count_writes(), 0);

    // Remount discards pending dirty data and reloads the current track.
    mount(1'b1, 1'b0);
    wait_quiet("rw_reload");
    write_byte(14'h0400);
    check("dirty_sec2", dirty, 13'h0004);
    log_q.delete();
    mount(1'b1, 1'b0);
    wait_quiet("remount_dirty");
    check("remount_no_writes", count_writes(), 0);
    if (log_q.size() > 0) check("remount_first", log_q[0].lba, 32'd91);

    // Track change while a load is running is picked up afterwards.
    set_track(9);
    repeat (30) @(negedge clk_sys);
    check("midload_busy", cpu_wait, 1'b1);
    set_track(10);
    wait_quiet("midload_change");

    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        write_byte(14'($urandom_range(0, 16383)));
        check("rnd_write_dirty", dirty, m_dirty);
      end else if (op <= 7) begin
        set_track($urandom_range(0, 63));
        wait_quiet("rnd_track");
      end else if (op == 8) begin
        mount($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        wait_quiet("rnd_mount");
      end else begin
        for (int k = 0; k < 4; k++) write_byte(14'($urandom_range(0, 13 * 512 - 1)));
        check("rnd_burst_dirty", dirty, m_dirty);
      end
    end

    // Reset while a read is outstanding.
    mount(1'b1, 1'b0);
    wait_quiet("pre_reset_mount");
    set_track((m_cur + 1) % 64);
    n = 0;
    while (!sd_rd && n < 500) begin @(negedge clk_sys); n++; end
    check("reset_saw_rd", sd_rd, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_midload", {sd_rd, sd_wr, cpu_wait, trk_valid}, 4'b0000);
    exp_q.delete();
    m_cur = 0; m_mounted = 0; m_ro = 0; m_valid = 0; m_dirty = '0;
    track = '0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    wait_quiet("after_reset");
    log_q.delete();
    mount(1'b1, 1'b0);
    wait_quiet("reload_after_reset");
    if (log_q.size() > 0) check("reload_first", log_q[0], {1'b0, 32'd0, 4'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fdd_track_sequencer.md
Name: fdd_track_sequencer

Overview:
- Sequences the one-track floppy buffer (13 × 512-byte sectors, 6656 bytes) against SD channel 0.
- Loads a full track whenever the drive's track number changes or a new image is mounted.
- Tracks which buffered sectors the disk controller has written, and writes those dirty sectors back to SD before the buffer is reused.
- Stalls the CPU while any SD transfer is in progress. Sits between apple2_top's disk interface and the SD block-request channel.

Parameters:
- SECTORS, 13: sectors per track; also the LBA multiplier.
- TRACK_W, 6: width of the track number.
- SEC_W, 4: width of the sector index; must satisfy 2^SEC_W ≥ SECTORS.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- track  in  TRACK_W  current head track from the disk controller.
- img_mounted  in  1  one-cycle pulse when an image is (re)mounted on drive 0.
- img_present  in  1  image size is nonzero; sampled together with img_mounted.
- img_readonly  in  1  image is write-protected; sampled together with img_mounted.
- fd_write_disk  in  1  disk controller writes one byte into the track buffer this cycle.
- fd_track_addr  in  14  buffer byte address of that write; bits [12:9] give the sector.
- sd_lba  out  32  SD block address.
- sd_rd  out  1  SD read request.
- sd_wr  out  1  SD write request.
- sd_ack  in  1  SD transfer in progress; a rise means accepted, a fall means complete.
- buf_sec  out  SEC_W  sector index driving the buffer's upper address bits during SD transfers.
- cpu_wait  out  1  holds the CPU while the sequencer is busy.
- trk_valid  out  1  buffer holds a fully loaded track of a present image.
- dirty  out  SECTORS  per-sector dirty mask, for debug.

Behaviour:
- Reset values (reset_n low, applied asynchronously): all outputs 0; state IDLE; cur_track 0; mounted flag 0; readonly flag 0.
- Registered state: cur_track, the mounted flag, the readonly flag, and a pending-remount flag.
- img_mounted pulse, in any state:
  - latch img_present into the mounted flag and img_readonly into the readonly flag;
  - set pending-remount;
  - clear dirty (the old image's writes are discarded);
  - clear trk_valid.
- States: IDLE, FLUSH_REQ, FLUSH_WAIT, LOAD_REQ, LOAD_WAIT.
- IDLE, checked in this priority order:
  1. pending-remount set or track ≠ cur_track, and dirty ≠ 0 and not a remount: go to FLUSH_REQ, with buf_sec = lowest set dirty bit.
  2. Otherwise, if pending-remount set or track ≠ cur_track: latch cur_track ← track and clear pending-remount. If the mounted flag is set: buf_sec ← 0, clear trk_valid, go to LOAD_REQ. If not: stay in IDLE with trk_valid 0.
- Dirty marking: in IDLE with trk_valid=1, readonly=0 and fd_write_disk=1, set dirty[fd_track_addr[12:9]]. Writes whose sector index is ≥ SECTORS are ignored. Writes in any other state are ignored.
- FLUSH_REQ:
  - sd_lba = SECTORS*cur_track + buf_sec, computed with a 32-bit zero-extended product;
  - sd_wr = 1;
  - go to FLUSH_WAIT.
- FLUSH_WAIT:
  - on a rising edge of sd_ack, drop sd_wr;
  - on a falling edge, clear dirty[buf_sec];
  - if any dirty bits remain, buf_sec ← next set bit (ascending) and go to FLUSH_REQ;
  - otherwise go to IDLE, which then sequences the load.
- LOAD_REQ:
  - sd_lba = SECTORS*cur_track + buf_sec;
  - sd_rd = 1;
  - go to LOAD_WAIT.
- LOAD_WAIT:
  - on a rising edge of sd_ack, drop sd_rd;
  - on a falling edge, if buf_sec = SECTORS-1: set trk_valid and go to IDLE;
  - otherwise increment buf_sec and go to LOAD_REQ.
- Edge detection on sd_ack uses a registered copy of sd_ack. sd_rd and sd_wr are never asserted together.
- cpu_wait = 1 in every state except IDLE. It also goes high in the same cycle IDLE decides to flush or load; it is registered alongside the state.
- Track change during FLUSH or LOAD: not acted on immediately. On return to IDLE, track ≠ cur_track is detected and the new track is sequenced. The load of the stale track completes first.
- img_mounted arriving during a FLUSH: the current sector write finishes, the remaining flush is abandoned (dirty is already cleared), and the sequencer returns to IDLE, which reloads.
- reset_n asserted mid-transfer: sd_rd and sd_wr drop immediately; the partial buffer is invalid (trk_valid 0).
- Latency: an SD transfer starts one cycle after a request is decided. A full load is 13 request/ack cycles.

Decomposition:
- Shared package fdd_pkg holds: SECTORS, TRACK_BYTES=6656, SECTOR_BYTES=512, and the state enum.
- One sub-module, fdd_dirty_tracker, owns the dirty mask register, set/clear/clear-all, and a lowest-set-bit priority encoder with an any-dirty flag.
- Track/LBA arithmetic and the FSM stay in fdd_track_sequencer.

Test Plan:
- Mount (img_present=1), track=0; the SD model acks each request after 10 cycles → sd_lba 0..12 in order, 13 sd_rd pulses, then trk_valid=1 and cpu_wait=0.
- After the load, set track=5 → sd_lba 65..77 with sd_rd, cpu_wait high throughout, buf_sec 0→12.
- With track 5 loaded, pulse fd_write_disk at fd_track_addr 0x0400 and 0x1800 (sectors 2 and 12), then set track=6 → sd_wr at lba 67, then 77; dirty → 0; then sd_rd at lba 78..90.
- Mount with img_readonly=1, write to sector 3, change track → no sd_wr is issued; only the reads occur.
- Pulse img_mounted with dirty=0x0004 while idle → dirty cleared, no flush, reload of cur_track.
- Deassert reset_n while sd_rd is high in LOAD_WAIT → sd_rd, cpu_wait and trk_valid all read 0 in the same cycle; after release, track 0 is reloaded once a mount occurs.
